// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// dmem_port_arbiter_pkg -- arbiter state encodings and default sizes. rev 1.0
// =============================================================================
package dmem_port_arbiter_pkg;

   localparam int DPA_ADDR_LEN     = 32;
   localparam int DPA_DATA_LEN     = 32;
   localparam int DPA_STARVE_LIMIT = 4;
   localparam int DPA_STARVE_W     = 3;

   typedef enum logic [1:0] {
      DPA_NORMAL = 2'd0,
      DPA_FORCE  = 2'd1,
      DPA_DRAIN  = 2'd2
   } dpa_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// =============================================================================
// dmem_port_arbiter_if -- load/store requester and data-memory signals. rev 1.0
// =============================================================================
interface dmem_port_arbiter_if
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_LEN = DPA_ADDR_LEN,
   parameter int DATA_LEN = DPA_DATA_LEN
);

   logic                load_req_i;
   logic [ADDR_LEN-1:0] load_addr_i;
   logic                load_gnt_o;
   logic                load_rvalid_o;
   logic [DATA_LEN-1:0] load_data_o;
   logic                st_valid_i;
   logic [ADDR_LEN-1:0] st_addr_i;
   logic [DATA_LEN-1:0] st_data_i;
   logic                st_ready_o;
   logic                drain_i;
   logic                drain_done_o;
   logic                mem_en_o;
   logic                mem_we_o;
   logic [ADDR_LEN-1:0] mem_addr_o;
   logic [DATA_LEN-1:0] mem_wdata_o;
   logic [DATA_LEN-1:0] mem_rdata_i;

   modport slave (
      input  load_req_i, load_addr_i, st_valid_i, st_addr_i, st_data_i,
             drain_i, mem_rdata_i,
      output load_gnt_o, load_rvalid_o, load_data_o, st_ready_o,
             drain_done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output load_req_i, load_addr_i, st_valid_i, st_addr_i, st_data_i,
             drain_i, mem_rdata_i,
      input  load_gnt_o, load_rvalid_o, load_data_o, st_ready_o,
             drain_done_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter_starve_counter.sv
`default_nettype none
// =============================================================================
// dpa_starve_counter -- saturating store-loss counter with limit-hit flag. rev 1.0
// =============================================================================
module dpa_starve_counter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int STARVE_W     = DPA_STARVE_W,
   parameter int STARVE_LIMIT = DPA_STARVE_LIMIT
) (
   input  wire logic clk_i,
   input  wire logic reset_i,
   input  wire logic clr,
   input  wire logic inc,
   output logic      limit_hit
);

   localparam logic [STARVE_W-1:0] HIT_VAL = STARVE_W'(STARVE_LIMIT - 1);
   localparam logic [STARVE_W-1:0] MAX_VAL = '1;

   logic [STARVE_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (!reset_i || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_VAL)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Asserted while the store has already lost LIMIT-1 times in a row.
   assign limit_hit = (cnt == HIT_VAL);

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// =============================================================================
// dmem_port_arbiter -- shares the single data-memory port between loads and
// store-buffer drain, with load priority, store anti-starvation and drain mode. rev 1.0
// =============================================================================
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_LEN     = DPA_ADDR_LEN,
   parameter int DATA_LEN     = DPA_DATA_LEN,
   parameter int STARVE_LIMIT = DPA_STARVE_LIMIT,
   parameter int STARVE_W     = DPA_STARVE_W
) (
   input wire logic             clk_i,
   input wire logic             reset_i,
   dmem_port_arbiter_if.slave   bus
);

   dpa_state_t          state;
   logic                load_gnt;
   logic                st_ready;
   logic                load_rvalid;
   logic                drain_done;
   logic                starve_inc;
   logic                starve_clr;
   logic                limit_hit;
   logic [ADDR_LEN-1:0] sel_addr;
   logic [DATA_LEN-1:0] wdata;

   always_comb begin
      load_gnt = 1'b0;
      st_ready = 1'b0;
      if (reset_i) begin
         case (state)
            DPA_NORMAL: begin
               load_gnt = bus.load_req_i;
               st_ready = bus.st_valid_i & ~bus.load_req_i;
            end
            DPA_FORCE, DPA_DRAIN: st_ready = bus.st_valid_i;
            default: ;
         endcase
      end
   end

   assign starve_inc = (state == DPA_NORMAL) & bus.st_valid_i & bus.load_req_i;
   assign starve_clr = (state != DPA_NORMAL) | ~bus.st_valid_i | st_ready;

   dpa_starve_counter #(
      .STARVE_W     (STARVE_W),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr       (starve_clr),
      .inc       (starve_inc),
      .limit_hit (limit_hit)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state       <= DPA_NORMAL;
         load_rvalid <= 1'b0;
         drain_done  <= 1'b0;
      end else begin
         load_rvalid <= load_gnt;
         drain_done  <= 1'b0;
         case (state)
            DPA_NORMAL: begin
               // drain_i is still high while the done pulse is out; don't restart.
               if (bus.drain_i && !drain_done) begin
                  state <= DPA_DRAIN;
               end else if (starve_inc && limit_hit) begin
                  state <= DPA_FORCE;
               end
            end
            DPA_FORCE: state <= DPA_NORMAL;
            DPA_DRAIN: begin
               if (!bus.st_valid_i) begin
                  drain_done <= 1'b1;
                  state      <= DPA_NORMAL;
               end
            end
            default: state <= DPA_NORMAL;
         endcase
      end
   end

   assign sel_addr = st_ready ? bus.st_addr_i : bus.load_addr_i;
   assign wdata    = bus.st_data_i;

   assign bus.load_gnt_o    = load_gnt;
   assign bus.st_ready_o    = st_ready;
   assign bus.load_rvalid_o = load_rvalid;
   assign bus.load_data_o   = bus.mem_rdata_i;
   assign bus.drain_done_o  = drain_done;
   assign bus.mem_en_o      = load_gnt | st_ready;
   assign bus.mem_we_o      = st_ready;
   assign bus.mem_addr_o    = sel_addr;
   assign bus.mem_wdata_o   = wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// =============================================================================
// tb_dmem_port_arbiter -- directed scenarios plus randomized traffic against a
// behavioural port-sharing model. rev 1.0
// =============================================================================
module tb_dmem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk     = 1'b0;
   logic        reset_i = 1'b0;
   int          checks  = 0;
   int          passes  = 0;
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   dmem_port_arbiter_if bus ();

   dmem_port_arbiter #(
      .ADDR_LEN     (32),
      .DATA_LEN     (32),
      .STARVE_LIMIT (LIMIT),
      .STARVE_W     (3)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory with one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_en_o) begin
         if (bus.mem_we_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
         else              bus.mem_rdata_i <= mem[bus.mem_addr_o[9:2]];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.load_req_i  = 1'b0;
      bus.load_addr_i = '0;
      bus.st_valid_i  = 1'b0;
      bus.st_addr_i   = '0;
      bus.st_data_i   = '0;
      bus.drain_i     = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      bus.load_req_i = 1'b1; bus.load_addr_i = 32'h100;
      bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h200; bus.drain_i = 1'b1;
      cyc(); cyc();
      @(negedge clk);
      checks++; if (bus.load_gnt_o !== 1'b0) $display("FAIL reset_load_gnt got %b want 0", bus.load_gnt_o); else passes++;
      checks++; if (bus.st_ready_o !== 1'b0) $display("FAIL reset_st_ready got %b want 0", bus.st_ready_o); else passes++;
      checks++; if (bus.mem_en_o !== 1'b0) $display("FAIL reset_mem_en got %b want 0", bus.mem_en_o); else passes++;
      checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL reset_mem_we got %b want 0", bus.mem_we_o); else passes++;
      checks++; if (bus.load_rvalid_o !== 1'b0) $display("FAIL reset_rvalid got %b want 0", bus.load_rvalid_o); else passes++;
      checks++; if (bus.drain_done_o !== 1'b0) $display("FAIL reset_drain_done got %b want 0", bus.drain_done_o); else passes++;
      cyc();
   endtask

   task automatic test_load();
      idle();
      reset_i = 1'b1;
      bus.load_req_i = 1'b1; bus.load_addr_i = 32'h100;
      @(negedge clk);
      checks++; if (bus.load_gnt_o !== 1'b1) $display("FAIL load_gnt got %b want 1", bus.load_gnt_o); else passes++;
      checks++; if (bus.mem_en_o !== 1'b1) $display("FAIL load_mem_en got %b want 1", bus.mem_en_o); else passes++;
      checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL load_mem_we got %b want 0", bus.mem_we_o); else passes++;
      checks++; if (bus.mem_addr_o !== 32'h100) $display("FAIL load_mem_addr got %h want 100", bus.mem_addr_o); else passes++;
      cyc();
      bus.load_req_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.load_rvalid_o !== 1'b1) $display("FAIL load_rvalid got %b want 1", bus.load_rvalid_o); else passes++;
      checks++; if (bus.load_data_o !== ref_mem[64]) $display("FAIL load_data got %h want %h", bus.load_data_o, ref_mem[64]); else passes++;
      cyc();
   endtask

   task automatic test_store();
      bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h200; bus.st_data_i = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (bus.st_ready_o !== 1'b1) $display("FAIL store_ready got %b want 1", bus.st_ready_o); else passes++;
      checks++; if (bus.mem_we_o !== 1'b1) $display("FAIL store_mem_we got %b want 1", bus.mem_we_o); else passes++;
      checks++; if (bus.mem_addr_o !== 32'h200) $display("FAIL store_mem_addr got %h want 200", bus.mem_addr_o); else passes++;
      checks++; if (bus.mem_wdata_o !== 32'hDEADBEEF) $display("FAIL store_wdata got %h want deadbeef", bus.mem_wdata_o); else passes++;
      ref_mem[128] = 32'hDEADBEEF;
      cyc();
      idle();
      bus.load_req_i = 1'b1; bus.load_addr_i = 32'h200;
      cyc();
      bus.load_req_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.load_data_o !== 32'hDEADBEEF) $display("FAIL store_readback got %h want deadbeef", bus.load_data_o); else passes++;
      cyc();
   endtask

   task automatic test_starve();
      bus.load_req_i = 1'b1; bus.load_addr_i = 32'h104;
      bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h204; bus.st_data_i = 32'h12345678;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (bus.load_gnt_o !== (c != 4)) $display("FAIL starve_load_gnt cycle %0d got %b want %b", c, bus.load_gnt_o, (c != 4)); else passes++;
         checks++; if (bus.st_ready_o !== (c == 4)) $display("FAIL starve_st_ready cycle %0d got %b want %b", c, bus.st_ready_o, (c == 4)); else passes++;
         cyc();
      end
      ref_mem[129] = 32'h12345678;
      idle();
      cyc();
   endtask

   task automatic test_no_starve();
      bus.load_req_i = 1'b1; bus.load_addr_i = 32'h108; bus.st_addr_i = 32'h208;
      for (int c = 0; c < 11; c++) begin
         bus.st_valid_i = (c == 0) || (c >= 7);
         @(negedge clk);
         checks++; if (bus.load_gnt_o !== 1'b1) $display("FAIL nostarve_load_gnt cycle %0d got %b want 1", c, bus.load_gnt_o); else passes++;
         checks++; if (bus.st_ready_o !== 1'b0) $display("FAIL nostarve_st_ready cycle %0d got %b want 0", c, bus.st_ready_o); else passes++;
         cyc();
      end
      idle();
      cyc(); cyc();
   endtask

   task automatic test_drain();
      int left = 3;
      logic [31:0] a;
      bus.load_req_i = 1'b1; bus.load_addr_i = 32'h10C; bus.drain_i = 1'b1;
      for (int c = 0; c < 7; c++) begin
         a = 32'h210 + 32'(4 * (3 - left));
         bus.st_valid_i = (left > 0); bus.st_addr_i = a; bus.st_data_i = 32'hD0000000 + 32'(left);
         @(negedge clk);
         checks++; if (bus.load_gnt_o !== (c == 0 || c >= 5)) $display("FAIL drain_load_gnt cycle %0d got %b want %b", c, bus.load_gnt_o, (c == 0 || c >= 5)); else passes++;
         checks++; if (bus.st_ready_o !== (c >= 1 && c <= 3)) $display("FAIL drain_st_ready cycle %0d got %b want %b", c, bus.st_ready_o, (c >= 1 && c <= 3)); else passes++;
         checks++; if (bus.drain_done_o !== (c == 5)) $display("FAIL drain_done cycle %0d got %b want %b", c, bus.drain_done_o, (c == 5)); else passes++;
         if (bus.st_ready_o && left > 0) begin
            ref_mem[a[9:2]] = bus.st_data_i;
            left--;
         end
         cyc();
         if (c == 5) bus.drain_i = 1'b0;
      end
      idle();
      cyc();
   endtask

   task automatic test_reset_mid();
      bus.drain_i = 1'b1; bus.st_valid_i = 1'b1; bus.st_addr_i = 32'h240; bus.st_data_i = 32'h0BADF00D;
      @(negedge clk);
      checks++; if (bus.st_ready_o !== 1'b1) $display("FAIL rstmid_st_ready got %b want 1", bus.st_ready_o); else passes++;
      ref_mem[144] = 32'h0BADF00D;
      cyc();
      reset_i = 1'b0; bus.load_req_i = 1'b1; bus.load_addr_i = 32'h110; bus.st_addr_i = 32'h244;
      @(negedge clk);
      checks++; if (bus.st_ready_o !== 1'b0) $display("FAIL rstmid_gated_st_ready got %b want 0", bus.st_ready_o); else passes++;
      checks++; if (bus.load_gnt_o !== 1'b0) $display("FAIL rstmid_gated_load_gnt got %b want 0", bus.load_gnt_o); else passes++;
      cyc();
      reset_i = 1'b1; bus.drain_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.load_gnt_o !== 1'b1) $display("FAIL rstmid_normal_load_gnt got %b want 1", bus.load_gnt_o); else passes++;
      checks++; if (bus.st_ready_o !== 1'b0) $display("FAIL rstmid_normal_st_ready got %b want 0", bus.st_ready_o); else passes++;
      checks++; if (bus.drain_done_o !== 1'b0) $display("FAIL rstmid_drain_done got %b want 0", bus.drain_done_o); else passes++;
      checks++; if (bus.load_rvalid_o !== 1'b0) $display("FAIL rstmid_rvalid got %b want 0", bus.load_rvalid_o); else passes++;
      cyc();
      reset_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.load_gnt_o !== 1'b0) $display("FAIL rstload_load_gnt got %b want 0", bus.load_gnt_o); else passes++;
      cyc();
      reset_i = 1'b1; idle();
      @(negedge clk);
      checks++; if (bus.load_rvalid_o !== 1'b0) $display("FAIL rstload_rvalid got %b want 0", bus.load_rvalid_o); else passes++;
      cyc();
   endtask

   // Model: loads win unless a store is being forced or the buffer is draining;
   // the LIMIT-th consecutive losing cycle of a waiting store forces it next cycle.
   task automatic test_random();
      bit          m_force = 1'b0, m_drain = 1'b0, m_done = 1'b0, m_prev_gnt = 1'b0;
      bit          eg = 1'b0, es = 1'b0, nxt_done, drop_drain = 1'b0;
      int          m_loss = 0, q_len = 0;
      logic [31:0] exp_data = '0, exp_addr;
      reset_i = 1'b0; idle();
      cyc(); cyc();
      reset_i = 1'b1;
      bus.st_addr_i = 32'($urandom_range(0, 63)) << 2; bus.st_data_i = $urandom;
      for (int n = 0; n < 400; n++) begin
         if (!bus.load_req_i || eg) begin
            bus.load_req_i  = ($urandom_range(0, 1) == 1);
            bus.load_addr_i = 32'($urandom_range(0, 63)) << 2;
         end
         if (q_len < 4 && $urandom_range(0, 2) == 0) q_len++;
         bus.st_valid_i = (q_len > 0);
         if (drop_drain) bus.drain_i = 1'b0;
         if (!bus.drain_i && $urandom_range(0, 39) == 0) bus.drain_i = 1'b1;
         @(negedge clk);
         if (m_force || m_drain) begin eg = 1'b0; es = bus.st_valid_i; end
         else begin eg = bus.load_req_i; es = bus.st_valid_i && !bus.load_req_i; end
         exp_addr = es ? bus.st_addr_i : bus.load_addr_i;
         checks++; if (bus.load_gnt_o !== eg) $display("FAIL rand_load_gnt n=%0d got %b want %b", n, bus.load_gnt_o, eg); else passes++;
         checks++; if (bus.st_ready_o !== es) $display("FAIL rand_st_ready n=%0d got %b want %b", n, bus.st_ready_o, es); else passes++;
         checks++; if (bus.mem_en_o !== (eg | es)) $display("FAIL rand_mem_en n=%0d got %b want %b", n, bus.mem_en_o, eg | es); else passes++;
         checks++; if (bus.mem_we_o !== es) $display("FAIL rand_mem_we n=%0d got %b want %b", n, bus.mem_we_o, es); else passes++;
         if (eg || es) begin
            checks++; if (bus.mem_addr_o !== exp_addr) $display("FAIL rand_mem_addr n=%0d got %h want %h", n, bus.mem_addr_o, exp_addr); else passes++;
         end
         checks++; if (bus.load_rvalid_o !== m_prev_gnt) $display("FAIL rand_rvalid n=%0d got %b want %b", n, bus.load_rvalid_o, m_prev_gnt); else passes++;
         checks++; if (bus.drain_done_o !== m_done) $display("FAIL rand_drain_done n=%0d got %b want %b", n, bus.drain_done_o, m_done); else passes++;
         if (m_prev_gnt) begin
            checks++; if (bus.load_data_o !== exp_data) $display("FAIL rand_load_data n=%0d got %h want %h", n, bus.load_data_o, exp_data); else passes++;
         end
         drop_drain = bus.drain_i && m_done;
         if (eg) exp_data = ref_mem[bus.load_addr_i[9:2]];
         if (es) begin
            ref_mem[bus.st_addr_i[9:2]] = bus.st_data_i;
            q_len--;
         end
         nxt_done = m_drain && !bus.st_valid_i;
         if (m_force) begin
            m_force = 1'b0; m_loss = 0;
         end else if (m_drain) begin
            if (!bus.st_valid_i) m_drain = 1'b0;
            m_loss = 0;
         end else begin
            m_loss = (bus.st_valid_i && bus.load_req_i) ? m_loss + 1 : 0;
            if (bus.drain_i && !m_done) begin m_drain = 1'b1; m_loss = 0; end
            else if (m_loss == LIMIT) begin m_force = 1'b1; m_loss = 0; end
         end
         m_done = nxt_done;
         m_prev_gnt = eg;
         cyc();
         if (es) begin
            bus.st_addr_i = 32'($urandom_range(0, 63)) << 2;
            bus.st_data_i = $urandom;
         end
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA5A50000 + 32'(i);
         ref_mem[i] = 32'hA5A50000 + 32'(i);
      end
      idle();
      test_reset();
      test_load();
      test_store();
      test_starve();
      test_no_starve();
      test_drain();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the single-port data memory. The port is shared between two requesters:
  - the load path of the memory access unit (read requests);
  - the store buffer drain (committed-store writes).
- Loads normally win. An anti-starvation counter forces a store through after repeated losses.
- A drain mode empties the store buffer for fences/flush.
- Sits between the EX memory access unit / store buffer and the data memory.

Parameters:
- ADDR_LEN, 32, address width (matches `ADDR_LEN).
- DATA_LEN, 32, data width (matches `DATA_LEN).
- STARVE_LIMIT, 4, consecutive cycles a valid store may lose before it is forced (legal range 1..2^STARVE_W-1).
- STARVE_W, 3, starvation counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- load_req_i  in  1  load wants the port this cycle.
- load_addr_i  in  ADDR_LEN  load effective address.
- load_gnt_o  out  1  load owns the port this cycle.
- load_rvalid_o  out  1  load data valid (1 cycle after grant).
- load_data_o  out  DATA_LEN  load read data.
- st_valid_i  in  1  store buffer head entry valid (0 = buffer empty).
- st_addr_i  in  ADDR_LEN  store address.
- st_data_i  in  DATA_LEN  store data.
- st_ready_o  out  1  store accepted this cycle (transfer = st_valid_i & st_ready_o).
- drain_i  in  1  level request: empty store buffer; held until drain_done_o.
- drain_done_o  out  1  one-cycle pulse: drain complete.
- mem_en_o  out  1  memory access enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_LEN  memory address.
- mem_wdata_o  out  DATA_LEN  memory write data.
- mem_rdata_i  in  DATA_LEN  memory read data, synchronous, 1-cycle latency.

Behaviour:
- Reset (reset_i==0 at posedge):
  - state=NORMAL, starve_cnt=0, load_rvalid_o=0, drain_done_o=0.
  - While reset_i is low, all grants and mem_en_o/mem_we_o are 0.
  - Reset mid-drain or mid-force abandons that state. Any in-flight load rvalid is dropped.
- Grants are combinational from state and current requests. At most one grant per cycle.
- mem_en_o = load_gnt_o | st_ready_o.
- mem_we_o = st_ready_o.
- mem_addr_o = st_ready_o ? st_addr_i : load_addr_i.
- mem_wdata_o = st_data_i.
- load_rvalid_o is registered: equals the previous cycle's load_gnt_o. load_data_o = mem_rdata_i (passthrough).
- FSM NORMAL:
  - load_gnt_o = load_req_i; st_ready_o = st_valid_i & ~load_req_i.
  - starve_cnt: +1 when st_valid_i & load_req_i; cleared on store transfer or when st_valid_i=0; saturates.
  - Next state:
    - if drain_i → DRAIN (priority over force);
    - else if st_valid_i & load_req_i & starve_cnt==STARVE_LIMIT-1 → FORCE.
- FSM FORCE:
  - load_gnt_o=0; st_ready_o=st_valid_i.
  - Next NORMAL always (one store max, or none if st_valid_i dropped). starve_cnt cleared.
  - drain_i seen in FORCE is acted on in the following NORMAL cycle.
- FSM DRAIN:
  - load_gnt_o=0; st_ready_o=st_valid_i.
  - When st_valid_i==0: drain_done_o=1 next cycle (registered pulse), next state NORMAL.
  - If the buffer is already empty on entry, the pulse comes 2 cycles after drain_i is first seen.
- Requester contract: a load not granted must hold load_req_i/load_addr_i stable. The arbiter keeps no queue.
- Loads never see store-buffer bypass here. Forwarding stays in the store buffer.

Decomposition:
- Shared consts header: state encodings DPA_NORMAL=2'd0, DPA_FORCE=2'd1, DPA_DRAIN=2'd2; default STARVE_LIMIT. Reuse `ADDR_LEN/`DATA_LEN.
- One natural sub-module: dpa_starve_counter (saturating counter with clear/inc and a limit-hit flag).
- Grant/mux logic and FSM stay in the top module.

Test Plan:
- Reset → all outputs 0. Then load_req_i=1, addr=0x100 → load_gnt_o=1, mem_en_o=1, mem_we_o=0, mem_addr_o=0x100. Next cycle load_rvalid_o=1, load_data_o=mem_rdata_i.
- st_valid_i=1, addr=0x200, data=0xDEADBEEF, no load → st_ready_o=1, mem_we_o=1, mem_addr_o=0x200, mem_wdata_o=0xDEADBEEF.
- Continuous load_req_i plus st_valid_i with STARVE_LIMIT=4:
  - loads granted cycles 0-3;
  - cycle 4: FORCE, load_gnt_o=0, store transferred;
  - cycle 5: load granted again, counter 0.
- Store valid in cycle 0 only, then st_valid_i drops during loads → counter clears, FORCE never entered.
- drain_i=1 with 3 stores queued and load_req_i=1 → 3 consecutive store transfers, load_gnt_o=0 throughout, drain_done_o pulses once the cycle after st_valid_i falls, then load granted.
- reset_i=0 asserted during DRAIN and in a cycle with a granted load → next cycle state NORMAL, load_rvalid_o=0, no drain_done_o pulse.
